// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the RV32I core front end.
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  localparam logic [1:0]  PCSRC_SEQ  = 2'b00;
  localparam logic [1:0]  PCSRC_BR   = 2'b01;
  localparam logic [1:0]  PCSRC_JALR = 2'b10;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall beats load; idle cycles insert a bubble.
module if_id_reg
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  // Stage register update; PC fields are left alone by flushes and bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= NOP_INSTR;
      pc       <= 32'h0;
      pc_plus4 <= 32'h0;
      valid    <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (stall) begin
      instr <= instr;
    end else if (load) begin
      instr    <= instr_in;
      pc       <= pc_in;
      pc_plus4 <= pc_in + 32'd4;
      valid    <= 1'b1;
    end else begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns PCF, runs the imem req/ack handshake and feeds IF/ID.
//
// state | meaning
// IDLE  | ready; requests PCF unless StallFetch
// WAIT  | request for PCF outstanding, waiting for ack
// DROP  | squashed request for DropAddr outstanding; its data is discarded
// HOLD  | fetched word parked in skid entry while decode is stalled
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallFetch,
  input  logic        StallDecode,
  input  logic        FlushDecode,
  input  logic [1:0]  PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] ALUResultE,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemRdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pcf, pcf_nxt;
  logic [31:0]  drop_addr, drop_addr_nxt;
  logic [31:0]  skid_instr, skid_pc;
  logic         skid_load, ifid_load, deliver, req;
  logic [31:0]  ifid_instr_in, ifid_pc_in;
  logic         redirect;
  logic [31:0]  target;

  assign redirect = (PCSrcE != PCSRC_SEQ);
  // PCSrcE = 11 falls back to the branch target.
  assign target   = word_align((PCSrcE == PCSRC_JALR) ? ALUResultE : PCTargetE);

  // Next-state, handshake and IF/ID load selection.
  always_comb begin
    state_nxt     = state;
    pcf_nxt       = pcf;
    drop_addr_nxt = drop_addr;
    req           = 1'b0;
    ImemAddr      = pcf;
    skid_load     = 1'b0;
    ifid_load     = 1'b0;
    deliver       = 1'b0;
    ifid_instr_in = ImemRdata;
    ifid_pc_in    = pcf;
    case (state)
      IDLE: begin
        req = !StallFetch;
        if (redirect) begin
          pcf_nxt = target;
          // A request the memory has seen but not answered must still be drained.
          if (req && !ImemAck) begin
            drop_addr_nxt = pcf;
            state_nxt     = DROP;
          end
        end else if (req) begin
          if (ImemAck) deliver = 1'b1;
          else         state_nxt = WAIT;
        end
      end
      WAIT: begin
        req = 1'b1;
        if (redirect) begin
          pcf_nxt = target;
          if (ImemAck) begin
            state_nxt = IDLE;
          end else begin
            drop_addr_nxt = pcf;
            state_nxt     = DROP;
          end
        end else if (ImemAck) begin
          deliver   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DROP: begin
        req      = 1'b1;
        ImemAddr = drop_addr;
        if (redirect) pcf_nxt = target;
        if (ImemAck)  state_nxt = IDLE;
      end
      HOLD: begin
        if (redirect || FlushDecode) begin
          if (redirect) pcf_nxt = target;
          state_nxt = IDLE;
        end else if (!StallDecode) begin
          ifid_load     = 1'b1;
          ifid_instr_in = skid_instr;
          ifid_pc_in    = skid_pc;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (deliver) begin
      pcf_nxt = pcf + 32'd4;
      if (!StallDecode) begin
        ifid_load = 1'b1;
      end else begin
        skid_load = 1'b1;
        state_nxt = HOLD;
      end
    end
  end

  assign ImemReq = req;

  // State, fetch PC, squashed address and skid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pcf        <= RESET_PC;
      drop_addr  <= 32'h0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= 32'h0;
    end else begin
      state     <= state_nxt;
      pcf       <= pcf_nxt;
      drop_addr <= drop_addr_nxt;
      if (skid_load) begin
        skid_instr <= ImemRdata;
        skid_pc    <= pcf;
      end
    end
  end

  if_id_reg u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (FlushDecode),
    .stall    (StallDecode),
    .load     (ifid_load),
    .instr_in (ifid_instr_in),
    .pc_in    (ifid_pc_in),
    .instr    (InstrD),
    .pc       (PCD),
    .pc_plus4 (PCPlus4D),
    .valid    (ValidD)
  );

endmodule
